piso_tx_arbiter: RTL and testbench

- Shares one parallel-in/serial-out shift register between two requesters.
- Each requester offers a WIDTH-bit word over a valid/ready handshake.
- A round-robin arbiter grants one word at a time; the controller loads it and shifts it out LSB-first, one bit per clock, with a frame strobe.
- Sits between parallel producers and a single serial link.

---
 rtl/piso_tx_pkg.sv | 13 +
 rtl/piso_shift_reg.sv | 29 ++
 rtl/piso_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_piso_tx_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared encodings for the two-requester PISO transmitter:
// FSM state values and requester indices.
package piso_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, right-shifting register; bit 0 is the serial output.
// A load takes priority over a shift in the same cycle.
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  output logic             ser_out
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= par_in;
    end else if (shift_en) begin
      r_q <= {ser_in, r_q[WIDTH-1:1]};
    end
  end

  assign ser_out = r_q[0];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter plus framing FSM sharing one PISO shift register
// between two valid/ready requesters; words go out LSB first.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | link quiet, ser_frame=0, any valid word may be accepted
// ST_SHIFT | bit r_cnt of the current word on ser_out; accept on last bit
module piso_tx_arbiter
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             ser_owner,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_owner;
  logic             r_last_grant;

  logic             w_last_bit;
  logic             w_window;
  logic             w_ready0;
  logic             w_ready1;
  logic             w_accept;
  logic             w_winner;
  logic [WIDTH-1:0] w_par_in;
  logic             w_load;
  logic             w_shift;

  assign w_last_bit = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);
  assign w_window   = (r_state == ST_IDLE) || w_last_bit;

  // On a tie the requester that was not granted last time wins.
  assign w_ready0 = !rst && w_window && req0_valid &&
                    (!req1_valid || (r_last_grant == REQ1));
  assign w_ready1 = !rst && w_window && req1_valid &&
                    (!req0_valid || (r_last_grant == REQ0));

  assign w_accept = w_ready0 || w_ready1;
  assign w_winner = w_ready1 ? REQ1 : REQ0;
  assign w_par_in = w_ready1 ? req1_data : req0_data;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_accept) begin
          w_cnt_nxt = '0;
          w_load    = 1'b1;
        end else if (w_last_bit) begin
          // One more shift flushes the register to zero so ser_out idles low.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_shift     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_shift   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_owner      <= REQ0;
      r_last_grant <= REQ1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
      end
    end
  end

  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .shift_en (w_shift),
    .par_in   (w_par_in),
    .ser_in   (1'b0),
    .ser_out  (ser_out)
  );

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign ser_frame  = (r_state == ST_SHIFT);
  assign ser_owner  = r_owner;
  assign done       = !rst && w_last_bit;

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Bench for piso_tx_arbiter: directed vector table, corner-case sequences
// and random traffic against a bit-queue model of the serial link.
module tb_piso_tx_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         ser_out, ser_frame, ser_owner, done;

  int total = 0;
  int bad   = 0;

  // Link model: bits still to be sent, front is on the wire this cycle.
  bit q_bits[$];
  bit m_last_grant;
  bit m_owner;

  logic s_r0, s_r1, s_out, s_frame, s_own, s_done;

  piso_tx_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .ser_out    (ser_out),
    .ser_frame  (ser_frame),
    .ser_owner  (ser_owner),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare against the model mid-cycle,
  // then advance the model across the next rising edge.
  task automatic step(input logic rs, input logic v0, input logic [W-1:0] d0,
                      input logic v1, input logic [W-1:0] d1, input bit check);
    bit e_r0, e_r1, e_out, e_frame, e_done, win;
    rst = rs; req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
    #4;
    win     = (q_bits.size() <= 1);
    e_r0    = !rs && win && v0 && (!v1 || m_last_grant == 1'b1);
    e_r1    = !rs && win && v1 && (!v0 || m_last_grant == 1'b0);
    e_frame = (q_bits.size() > 0);
    e_out   = e_frame ? q_bits[0] : 1'b0;
    e_done  = !rs && (q_bits.size() == 1);
    s_r0 = req0_ready; s_r1 = req1_ready; s_out = ser_out;
    s_frame = ser_frame; s_own = ser_owner; s_done = done;
    if (check) begin
      chk("m_ready0", s_r0, e_r0);
      chk("m_ready1", s_r1, e_r1);
      chk("m_ser_out", s_out, e_out);
      chk("m_ser_frame", s_frame, e_frame);
      chk("m_ser_owner", s_own, m_owner);
      chk("m_done", s_done, e_done);
    end
    if (rs) begin
      q_bits.delete();
      m_last_grant = 1'b1;
      m_owner      = 1'b0;
    end else begin
      if (q_bits.size() > 0) void'(q_bits.pop_front());
      if (e_r0 || e_r1) begin
        for (int k = 0; k < W; k++) q_bits.push_back(e_r1 ? d1[k] : d0[k]);
        m_last_grant = e_r1;
        m_owner      = e_r1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         rs;
    logic         v0;
    logic [W-1:0] d0;
    logic         v1;
    logic [W-1:0] d1;
    logic         r0, r1, out, frame, own, dn;
  } vec_t;

  vec_t tv[18];

  initial begin
    int grants[$];
    int n_done;
    int r1_acc;

    //          rs    v0    d0     v1    d1     r0    r1    out   frm   own   done
    tv[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 4'hB, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 4'hA, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 4'hA, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[10] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[12] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[13] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[14] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[15] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[16] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tv[17] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    m_last_grant = 1'b1; m_owner = 1'b0;
    @(posedge clk);
    #1;

    // Directed table: single word 4'hB, then tie 4'hA vs 4'h5 after reset.
    for (int i = 0; i < 18; i++) begin
      step(tv[i].rs, tv[i].v0, tv[i].d0, tv[i].v1, tv[i].d1, 1'b1);
      chk($sformatf("tv%0d_ready0", i), s_r0, tv[i].r0);
      chk($sformatf("tv%0d_ready1", i), s_r1, tv[i].r1);
      chk($sformatf("tv%0d_ser_out", i), s_out, tv[i].out);
      chk($sformatf("tv%0d_ser_frame", i), s_frame, tv[i].frame);
      chk($sformatf("tv%0d_ser_owner", i), s_own, tv[i].own);
      chk($sformatf("tv%0d_done", i), s_done, tv[i].dn);
    end

    // Fairness: both valid continuously.
    step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    n_done = 0;
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, W'($urandom), 1'b1, W'($urandom), 1'b1);
      chk("fair_not_both", s_r0 && s_r1, 1'b0);
      if (s_r0) grants.push_back(0);
      if (s_r1) grants.push_back(1);
      if (s_done) n_done++;
    end
    chk("fair_grant_count", grants.size() == 5, 1'b1);
    for (int i = 0; i < grants.size() && i < 5; i++)
      chk($sformatf("fair_grant%0d", i), grants[i][0], i[0]);
    chk("fair_done_count", n_done == 4, 1'b1);
    for (int i = 0; i < W; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Mid-frame request: req1 rises at counter 1, must wait for the last bit.
    step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 4'h6, 1'b0, 4'h0, 1'b1);
    chk("mid_acc0", s_r0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1, 4'h9, 1'b1);
    chk("mid_cnt1_ready1", s_r1, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1, 4'h9, 1'b1);
    chk("mid_cnt2_ready1", s_r1, 1'b0);
    chk("mid_cnt2_bit", s_out, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1, 4'h9, 1'b1);
    chk("mid_cnt3_ready1", s_r1, 1'b1);
    chk("mid_cnt3_bit", s_out, 1'b0);
    for (int i = 0; i < W + 1; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    chk("mid_idle", s_frame, 1'b0);

    // Reset mid-word at counter 2 of 4'hF.
    step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
    chk("rstmid_ready0", s_r0, 1'b0);
    chk("rstmid_ready1", s_r1, 1'b0);
    chk("rstmid_done", s_done, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    chk("rstmid_frame", s_frame, 1'b0);
    chk("rstmid_out", s_out, 1'b0);
    chk("rstmid_done_after", s_done, 1'b0);
    step(1'b0, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
    chk("rstmid_tie_r0", s_r0, 1'b1);
    chk("rstmid_tie_r1", s_r1, 1'b0);
    for (int i = 0; i < W; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Valid withdrawn: one-cycle req1 pulse outside the accept window.
    step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    r1_acc = 0;
    step(1'b0, 1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1, 4'hE, 1'b1);
    if (s_r1) r1_acc++;
    for (int i = 0; i < W + 2; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      if (s_r1) r1_acc++;
    end
    chk("wd_no_accept", r1_acc == 0, 1'b1);
    chk("wd_idle", s_frame, 1'b0);

    // Random traffic against the model.
    step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 64) == 0, ($urandom % 3) != 0, W'($urandom),
           ($urandom % 3) != 0, W'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
